gmii_tx_framer: RTL and testbench
=================================

# gmii_tx_framer

Parametrised GMII transmit framer. It sits between a byte-stream packet source (valid/ready/last) and the GMII transmit pins, in the `GTX_CLK` domain. It inserts the preamble and SFD, pads short frames, appends CRC-32 FCS and enforces the inter-frame gap. Preamble length, gap length, minimum frame size, padding and FCS generation are configurable, and it flags source underrun and byte-level errors on `TX_ER`.

## Interface
- `PREAMBLE_BYTES`, default 7: number of 0x55 bytes before SFD; legal range 1..15.
- `IFG_BYTES`, default 12: idle cycles (TX_EN=0) after each frame; legal range 1..255.
- `MIN_FRAME`, default 60: minimum byte count of data plus pad, FCS excluded; legal range 0..1514.
- `ENABLE_PAD`, default 1: 1 = pad short frames with 0x00 up to `MIN_FRAME`.
- `ENABLE_CRC`, default 1: 1 = append the 4-byte FCS.

Ports (one clock; reset is asynchronous and active-high):
- `GTX_CLK` in 1: transmit clock; all logic is on its rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `S_DATA` in 8: payload byte.
- `S_VALID` in 1: `S_DATA`, `S_LAST` and `S_ERR` are valid.
- `S_READY` out 1: framer accepts a byte this cycle.
- `S_LAST` in 1: the accepted byte is the last one of the frame.
- `S_ERR` in 1: the accepted byte is corrupt; propagate it on `TX_ER`.
- `TXD` out 8: GMII transmit data, registered.
- `TX_EN` out 1: GMII transmit enable, registered.
- `TX_ER` out 1: GMII transmit error, registered.
- `FRAME_DONE` out 1: one-cycle pulse when the last FCS (or last data/pad) byte is driven.
- `UNDERRUN` out 1: one-cycle pulse when a frame is aborted for source underrun.

## Operation
- Reset values: `TXD`=0x00, `TX_EN`=0, `TX_ER`=0, `S_READY`=0, `FRAME_DONE`=0, `UNDERRUN`=0. State = IDLE; counters and CRC cleared.
- A byte is accepted when `S_VALID && S_READY`. `S_READY` is high only in the DATA and DROP states.
- State machine:
  - IDLE: if `S_VALID` is high, go to PRE. The first byte is not consumed.
  - PRE: drive 0x55 with `TX_EN`=1 for `PREAMBLE_BYTES` cycles, then drive 0xD5 (SFD) and enter DATA.
  - DATA: each accepted byte is driven on the next edge, with `TX_ER`=`S_ERR`. The CRC is updated and the byte count is incremented, saturating at 2047.
    - Accepted `S_LAST`: go to PAD if `ENABLE_PAD` and count < `MIN_FRAME`; else FCS if `ENABLE_CRC`; else IFG.
  - DATA underrun: `S_VALID`=0 while in DATA. Drive `TXD`=0x00, `TX_EN`=1, `TX_ER`=1 for one cycle and pulse `UNDERRUN`. Go to DROP if the last byte has not been seen, else IFG. No pad and no FCS are sent.
  - DROP: `TX_EN`=0 and `S_READY`=1. Discard bytes until `S_LAST` is accepted, then go to IFG.
  - PAD: drive 0x00 (included in the CRC) until count = `MIN_FRAME`, then go to FCS or IFG.
  - FCS: drive 4 bytes, then go to IFG.
  - IFG: `TX_EN`=0, `TXD`=0x00 for `IFG_BYTES` cycles, then go to IDLE.
- CRC: IEEE 802.3 reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF at SFD, computed over data and pad. FCS = ~CRC, sent least significant byte first.
- `FRAME_DONE` pulses with the final non-IFG byte of a normal frame. It is not asserted on aborted frames.
- `RESET` mid-frame: all outputs return to reset values immediately. After release the framer is in IDLE, with no IFG enforced.

## Timing
- Latency: when `S_VALID` is sampled high in IDLE at edge k, the first 0x55 appears after edge k+1. SFD is on the wire during cycle `PREAMBLE_BYTES`+1 after TX_EN rises.
- `S_READY` goes high in the same cycle that 0xD5 is driven. A byte accepted at edge n appears on `TXD` after edge n.
- A frame with N ≥ `MIN_FRAME` data bytes and CRC enabled holds `TX_EN` high for exactly `PREAMBLE_BYTES`+1+N+4 cycles.
- Back-to-back frames: `TX_EN` is low for exactly `IFG_BYTES` cycles, plus 1 cycle for IDLE detection, between frames.
- `S_READY` is never high in PRE, PAD, FCS, IFG or IDLE.

## Test plan
- Defaults, 60 zero bytes with `S_VALID` held high: 7×0x55, 0xD5, 60×0x00, then FCS; `TX_EN` high 72 cycles; `FRAME_DONE` pulses once with the 4th FCS byte.
- `MIN_FRAME`=0, payload ASCII "123456789": FCS bytes 0x26 0x39 0xF4 0xCB; `TX_EN` high 7+1+9+4=21 cycles.
- Defaults, 10-byte frame: 50 pad bytes of 0x00 follow, then the FCS over all 60 bytes; the counts check against a reference model.
- `S_VALID` dropped after byte 5 of a 20-byte frame: one cycle with `TX_EN`=1, `TX_ER`=1, `TXD`=0x00; `UNDERRUN` pulses; the remaining 15 bytes are accepted with `TX_EN`=0; `IFG_BYTES` idle cycles follow; no `FRAME_DONE`.
- Two back-to-back 64-byte frames, `IFG_BYTES`=12: 13 low cycles of `TX_EN` between frames. A byte with `S_ERR`=1 at index 3 gives `TX_ER`=1 on exactly that byte.
- `RESET` pulsed during the FCS: all outputs go to 0 within the cycle; the next frame starts with a full preamble and the correct CRC.

Source files
------------

// File: rtl/gmii_tx_framer.sv
// rtl/gmii_tx_framer.sv - GMII transmit framer: preamble/SFD, pad, CRC-32 FCS, inter-frame gap
//
// Ports:
//   GTX_CLK, RESET           transmit clock, asynchronous active-high reset
//   S_DATA/S_VALID/S_READY   byte-stream source handshake
//   S_LAST, S_ERR            end-of-frame marker, corrupt-byte marker
//   TXD, TX_EN, TX_ER        registered GMII transmit pins
//   FRAME_DONE               pulse with the final byte of a completed frame
//   UNDERRUN                 pulse when a frame is aborted for source underrun
module gmii_tx_framer #(
   parameter int PREAMBLE_BYTES = 7,
   parameter int IFG_BYTES      = 12,
   parameter int MIN_FRAME      = 60,
   parameter int ENABLE_PAD     = 1,
   parameter int ENABLE_CRC     = 1
) (
   input  logic       GTX_CLK,
   input  logic       RESET,
   input  logic [7:0] S_DATA,
   input  logic       S_VALID,
   output logic       S_READY,
   input  logic       S_LAST,
   input  logic       S_ERR,
   output logic [7:0] TXD,
   output logic       TX_EN,
   output logic       TX_ER,
   output logic       FRAME_DONE,
   output logic       UNDERRUN
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_DATA,
      ST_DROP,
      ST_PAD,
      ST_FCS,
      ST_IFG
   } state_t;

   localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES);
   localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
   localparam logic [11:0] MIN_W    = 12'(MIN_FRAME);

   state_t      state;
   logic [7:0]  step;       // preamble, FCS and gap cycle counter
   logic [10:0] byte_cnt;   // data + pad bytes sent, saturating
   logic [31:0] crc;

   logic [10:0] cnt_inc;
   logic        pad_needed;
   logic [31:0] fcs;
   logic [7:0]  fcs_byte;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   assign cnt_inc = (byte_cnt == 11'd2047) ? byte_cnt : byte_cnt + 11'd1;
   // Written as (count + 1) <= MIN so MIN_FRAME = 0 is not a constant-false compare.
   assign pad_needed = (ENABLE_PAD != 0) && (({1'b0, cnt_inc} + 12'd1) <= MIN_W);
   assign fcs = ~crc;
   assign S_READY = (state == ST_DATA) || (state == ST_DROP);

   always_comb begin
      fcs_byte = fcs[7:0];
      case (step[1:0])
         2'd0: fcs_byte = fcs[7:0];
         2'd1: fcs_byte = fcs[15:8];
         2'd2: fcs_byte = fcs[23:16];
         2'd3: fcs_byte = fcs[31:24];
         default: fcs_byte = fcs[7:0];
      endcase
   end

   always_ff @(posedge GTX_CLK or posedge RESET) begin
      if (RESET) begin
         state      <= ST_IDLE;
         step       <= 8'd0;
         byte_cnt   <= 11'd0;
         crc        <= 32'd0;
         TXD        <= 8'h00;
         TX_EN      <= 1'b0;
         TX_ER      <= 1'b0;
         FRAME_DONE <= 1'b0;
         UNDERRUN   <= 1'b0;
      end else begin
         FRAME_DONE <= 1'b0;
         UNDERRUN   <= 1'b0;
         case (state)
            ST_IDLE: begin
               TXD      <= 8'h00;
               TX_EN    <= 1'b0;
               TX_ER    <= 1'b0;
               step     <= 8'd0;
               byte_cnt <= 11'd0;
               if (S_VALID) begin
                  state <= ST_PRE;
               end
            end
            ST_PRE: begin
               TX_EN <= 1'b1;
               TX_ER <= 1'b0;
               if (step == PRE_LAST) begin
                  TXD      <= 8'hD5;
                  crc      <= 32'hFFFFFFFF;
                  byte_cnt <= 11'd0;
                  state    <= ST_DATA;
               end else begin
                  TXD  <= 8'h55;
                  step <= step + 8'd1;
               end
            end
            ST_DATA: begin
               TX_EN <= 1'b1;
               if (S_VALID) begin
                  TXD      <= S_DATA;
                  TX_ER    <= S_ERR;
                  crc      <= crc_byte(crc, S_DATA);
                  byte_cnt <= cnt_inc;
                  if (S_LAST) begin
                     step <= 8'd0;
                     if (pad_needed) begin
                        state <= ST_PAD;
                     end else if (ENABLE_CRC != 0) begin
                        state <= ST_FCS;
                     end else begin
                        state      <= ST_IFG;
                        FRAME_DONE <= 1'b1;
                     end
                  end
               end else begin
                  // Source ran dry mid-frame: poison one byte, then swallow the rest.
                  TXD      <= 8'h00;
                  TX_ER    <= 1'b1;
                  UNDERRUN <= 1'b1;
                  state    <= ST_DROP;
               end
            end
            ST_DROP: begin
               TXD   <= 8'h00;
               TX_EN <= 1'b0;
               TX_ER <= 1'b0;
               if (S_VALID && S_LAST) begin
                  step  <= 8'd0;
                  state <= ST_IFG;
               end
            end
            ST_PAD: begin
               TXD      <= 8'h00;
               TX_EN    <= 1'b1;
               TX_ER    <= 1'b0;
               crc      <= crc_byte(crc, 8'h00);
               byte_cnt <= cnt_inc;
               if (!pad_needed) begin
                  step <= 8'd0;
                  if (ENABLE_CRC != 0) begin
                     state <= ST_FCS;
                  end else begin
                     state      <= ST_IFG;
                     FRAME_DONE <= 1'b1;
                  end
               end
            end
            ST_FCS: begin
               TXD   <= fcs_byte;
               TX_EN <= 1'b1;
               TX_ER <= 1'b0;
               if (step == 8'd3) begin
                  step       <= 8'd0;
                  FRAME_DONE <= 1'b1;
                  state      <= ST_IFG;
               end else begin
                  step <= step + 8'd1;
               end
            end
            ST_IFG: begin
               TXD   <= 8'h00;
               TX_EN <= 1'b0;
               TX_ER <= 1'b0;
               if (step == IFG_LAST) begin
                  step  <= 8'd0;
                  state <= ST_IDLE;
               end else begin
                  step <= step + 8'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb/tb_gmii_tx_framer.sv - self-checking bench for gmii_tx_framer
module tb_gmii_tx_framer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] s_data;
   logic       s_valid, s_last, s_err;
   logic       sel;   // 0 = default instance, 1 = MIN_FRAME=0 instance

   logic       rdy0, en0, er0, done0, und0;
   logic       rdy1, en1, er1, done1, und1;
   logic [7:0] txd0, txd1;
   logic       rdy, en, er, done, und;
   logic [7:0] txd;

   always #4 clk = ~clk;

   gmii_tx_framer u_dut0 (
      .GTX_CLK(clk), .RESET(rst), .S_DATA(s_data), .S_VALID(s_valid & ~sel),
      .S_READY(rdy0), .S_LAST(s_last), .S_ERR(s_err), .TXD(txd0), .TX_EN(en0),
      .TX_ER(er0), .FRAME_DONE(done0), .UNDERRUN(und0)
   );

   gmii_tx_framer #(.MIN_FRAME(0)) u_dut1 (
      .GTX_CLK(clk), .RESET(rst), .S_DATA(s_data), .S_VALID(s_valid & sel),
      .S_READY(rdy1), .S_LAST(s_last), .S_ERR(s_err), .TXD(txd1), .TX_EN(en1),
      .TX_ER(er1), .FRAME_DONE(done1), .UNDERRUN(und1)
   );

   assign rdy  = sel ? rdy1  : rdy0;
   assign txd  = sel ? txd1  : txd0;
   assign en   = sel ? en1   : en0;
   assign er   = sel ? er1   : er0;
   assign done = sel ? done1 : done0;
   assign und  = sel ? und1  : und0;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic [7:0] wire_q[$];
   logic       er_q[$];
   int         done_cnt, und_cnt, done_pos, low_run, bad_rise;
   int         gap_q[$];
   logic       prev_en = 1'b0, prev_rdy = 1'b0;

   task automatic clear_mon();
      wire_q.delete(); er_q.delete(); gap_q.delete();
      done_cnt = 0; und_cnt = 0; done_pos = -1;
   endtask

   always @(negedge clk) begin
      if (en) begin
         if (!prev_en) gap_q.push_back(low_run);
         wire_q.push_back(txd);
         er_q.push_back(er);
         low_run = 0;
      end else begin
         low_run++;
      end
      if (done) begin
         done_cnt++;
         done_pos = wire_q.size();
      end
      if (und) und_cnt++;
      // READY may only rise together with the SFD
      if (!rst && rdy && !prev_rdy && !(en && txd == 8'hD5)) bad_rise++;
      prev_en  = en;
      prev_rdy = rdy;
   end

   // ---------------- reference model ----------------
   logic [31:0] crc_tab[256];
   logic [7:0]  pay[$];
   logic [7:0]  exp_q[$];
   logic        exper_q[$];

   function automatic logic [31:0] crc_of(input logic [7:0] q[$]);
      logic [31:0] c = 32'hFFFFFFFF;
      foreach (q[i]) c = (c >> 8) ^ crc_tab[(c[7:0] ^ q[i])];
      return ~c;
   endfunction

   task automatic build_exp(input int min_frame, input int err_idx, input int drop_after);
      logic [7:0] frame[$];
      logic [31:0] f;
      exp_q.delete(); exper_q.delete();
      for (int i = 0; i < 7; i++) begin exp_q.push_back(8'h55); exper_q.push_back(1'b0); end
      exp_q.push_back(8'hD5); exper_q.push_back(1'b0);
      if (drop_after >= 0) begin
         for (int i = 0; i < drop_after; i++) begin
            exp_q.push_back(pay[i]); exper_q.push_back(i == err_idx);
         end
         exp_q.push_back(8'h00); exper_q.push_back(1'b1);
         return;
      end
      frame = pay;
      while (frame.size() < min_frame) frame.push_back(8'h00);
      foreach (frame[i]) begin
         exp_q.push_back(frame[i]); exper_q.push_back(i == err_idx);
      end
      f = crc_of(frame);
      for (int b = 0; b < 4; b++) begin
         exp_q.push_back(f[8*b +: 8]); exper_q.push_back(1'b0);
      end
   endtask

   task automatic cmp_wire(input string nm);
      int bad_i = -1;
      if (wire_q.size() == exp_q.size()) begin
         foreach (exp_q[i]) if (bad_i < 0 && (wire_q[i] !== exp_q[i] || er_q[i] !== exper_q[i])) bad_i = i;
      end
      n_cmp++;
      if (wire_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL %s: wire length got %0d expected %0d", nm, wire_q.size(), exp_q.size());
      end else if (bad_i >= 0) begin
         n_bad++;
         $display("FAIL %s: byte %0d got %0h/er%0b expected %0h/er%0b", nm, bad_i,
                  wire_q[bad_i], er_q[bad_i], exp_q[bad_i], exper_q[bad_i]);
      end
   endtask

   // ---------------- driver ----------------
   task automatic make_pay(input int len, input int pat);
      pay.delete();
      for (int i = 0; i < len; i++) begin
         case (pat)
            0: pay.push_back(8'h00);
            1: pay.push_back(8'h31 + 8'(i % 9));
            2: pay.push_back(8'(i));
            default: pay.push_back(8'($urandom));
         endcase
      end
   endtask

   task automatic send(input int drop_after, input int err_idx);
      int i = 0;
      int guard = 0;
      bit dropped = 1'b0;
      while (i < pay.size() && guard < 2000) begin
         @(negedge clk);
         guard++;
         if (drop_after >= 0 && i == drop_after && !dropped) begin
            s_valid = 1'b0;
            dropped = 1'b1;
         end else begin
            s_valid = 1'b1;
            s_data  = pay[i];
            s_last  = (i == pay.size() - 1);
            s_err   = (i == err_idx);
            if (rdy) i++;
         end
      end
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0;
      if (guard >= 2000) check("send_timeout", 32'(i), 32'(pay.size()));
   endtask

   task automatic start_test(input logic sel_v);
      @(posedge clk); #1;
      sel = sel_v;
      clear_mon();
   endtask

   typedef struct {
      int          len;
      int          pat;
      logic        sel;
      int          err_idx;
      int          drop;
      int          exp_en;
      int          exp_done;
      int          exp_und;
      logic [31:0] exp_fcs;   // 0 = take FCS from the model only
   } vec_t;

   vec_t vecs[8];

   initial begin
      // CRC lookup table from the reflected polynomial
      for (int n = 0; n < 256; n++) begin
         logic [31:0] c;
         c = 32'(n);
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         crc_tab[n] = c;
      end

      vecs[0] = '{60, 0, 1'b0, -1, -1, 72, 1, 0, 32'h0};
      vecs[1] = '{ 9, 1, 1'b1, -1, -1, 21, 1, 0, 32'hCBF43926};
      vecs[2] = '{10, 2, 1'b0, -1, -1, 72, 1, 0, 32'h0};
      vecs[3] = '{20, 2, 1'b0, -1,  5, 14, 0, 1, 32'h0};
      vecs[4] = '{64, 2, 1'b0,  3, -1, 76, 1, 0, 32'h0};
      vecs[5] = '{ 1, 2, 1'b1, -1, -1, 13, 1, 0, 32'h0};
      vecs[6] = '{59, 2, 1'b0, -1, -1, 72, 1, 0, 32'h0};
      vecs[7] = '{61, 2, 1'b0, -1, -1, 73, 1, 0, 32'h0};

      rst = 1'b1; sel = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0; s_data = 8'h00;
      low_run = 0; bad_rise = 0;
      clear_mon();
      repeat (3) @(negedge clk);
      check("reset_dut0", {txd0, en0, er0, rdy0, done0, und0}, 32'h0);
      check("reset_dut1", {txd1, en1, er1, rdy1, done1, und1}, 32'h0);
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);

      // table-driven frames
      foreach (vecs[v]) begin
         int n;
         start_test(vecs[v].sel);
         make_pay(vecs[v].len, vecs[v].pat);
         send(vecs[v].drop, vecs[v].err_idx);
         repeat (100) @(negedge clk);
         build_exp(vecs[v].sel ? 0 : 60, vecs[v].err_idx, vecs[v].drop);
         check($sformatf("v%0d_txen_cycles", v), 32'(wire_q.size()), 32'(vecs[v].exp_en));
         check($sformatf("v%0d_frame_done", v), 32'(done_cnt), 32'(vecs[v].exp_done));
         check($sformatf("v%0d_underrun", v), 32'(und_cnt), 32'(vecs[v].exp_und));
         cmp_wire($sformatf("v%0d_wire", v));
         if (vecs[v].exp_done == 1)
            check($sformatf("v%0d_done_pos", v), 32'(done_pos), 32'(wire_q.size()));
         n = wire_q.size();
         if (vecs[v].exp_fcs != 32'h0 && n >= 4)
            check($sformatf("v%0d_fcs", v), {wire_q[n-1], wire_q[n-2], wire_q[n-3], wire_q[n-4]},
                  vecs[v].exp_fcs);
      end

      // first-preamble latency
      start_test(1'b0);
      make_pay(60, 2);
      @(negedge clk);
      s_valid = 1'b1; s_data = pay[0]; s_last = 1'b0; s_err = 1'b0;
      @(negedge clk);
      check("lat_idle_cycle", {31'd0, en}, 32'd0);
      @(negedge clk);
      check("lat_first_pre", {23'd0, en, txd}, {23'd0, 1'b1, 8'h55});
      send(-1, -1);
      repeat (100) @(negedge clk);
      build_exp(60, -1, -1);
      cmp_wire("lat_wire");

      // back-to-back 64-byte frames
      start_test(1'b0);
      make_pay(64, 3);
      send(-1, -1);
      send(-1, -1);
      repeat (100) @(negedge clk);
      check("b2b_done", 32'(done_cnt), 32'd2);
      check("b2b_wire_len", 32'(wire_q.size()), 32'd152);
      if (gap_q.size() >= 2) check("b2b_gap", 32'(gap_q[gap_q.size()-1]), 32'd13);
      else check("b2b_gap_seen", 32'(gap_q.size()), 32'd2);

      // reset during FCS
      begin
         int g = 0;
         start_test(1'b0);
         make_pay(60, 3);
         send(-1, -1);
         while (wire_q.size() < 70 && g < 200) begin @(negedge clk); g++; end
         check("rst_reach_fcs", 32'(g < 200), 32'd1);
         #1 rst = 1'b1;
         #1 check("rst_outputs", {txd, en, er, rdy, done, und}, 32'h0);
         @(negedge clk); rst = 1'b0;
      end
      start_test(1'b0);
      send(-1, -1);
      repeat (100) @(negedge clk);
      build_exp(60, -1, -1);
      cmp_wire("post_rst_wire");
      check("post_rst_done", 32'(done_cnt), 32'd1);

      // randomized frames against the model
      for (int r = 0; r < 24; r++) begin
         logic sv;
         int   len, ei;
         sv  = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 90);
         ei  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
         start_test(sv);
         make_pay(len, 3);
         send(-1, ei);
         repeat (100) @(negedge clk);
         build_exp(sv ? 0 : 60, ei, -1);
         cmp_wire($sformatf("rnd%0d_wire", r));
         check($sformatf("rnd%0d_done", r), 32'(done_cnt), 32'd1);
      end

      check("ready_rise_with_sfd", 32'(bad_rise), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
